// File: rtl/dualportram_port_arbiter.sv
// Round-robin, burst-bounded arbiter that shares one dualportram port among NREQ masters.
// Grants are combinational (access issued in the grant cycle); read data returns one cycle later.
module dualportram_port_arbiter #(
   parameter int unsigned NREQ      = 4,
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ-1:0]       req_we,
   input  logic [NREQ*32-1:0]    req_address,
   input  logic [NREQ*WIDTH-1:0] req_din,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       rvalid,
   output logic [WIDTH-1:0]      rdata,
   output logic                  ram_we,
   output logic                  ram_oe,
   output logic [31:0]           ram_address,
   output logic [WIDTH-1:0]      ram_din,
   input  logic [WIDTH-1:0]      ram_dout
);

   localparam int unsigned AW   = 32;
   localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CW   = $clog2(MAX_BURST + 1);

   logic [IDXW-1:0] owner, owner_n;
   logic            owner_vld, owner_vld_n;
   logic [CW-1:0]   burst_cnt, burst_cnt_n;
   logic [IDXW-1:0] last, last_n;
   logic [NREQ-1:0] rd_pend, rd_pend_n;

   logic [IDXW-1:0] gnt_idx;
   logic            gnt_any;
   logic            owner_keep;
   int unsigned     scan_idx;

   // State registers
   always_ff @(posedge clk) begin
      if (reset) begin
         owner     <= '0;
         owner_vld <= 1'b0;
         burst_cnt <= '0;
         last      <= IDXW'(NREQ - 1);
         rd_pend   <= '0;
      end else begin
         owner     <= owner_n;
         owner_vld <= owner_vld_n;
         burst_cnt <= burst_cnt_n;
         last      <= last_n;
         rd_pend   <= rd_pend_n;
      end
   end

   // Grant selection, next state and RAM drive
   always_comb begin
      gnt_idx     = '0;
      gnt_any     = 1'b0;
      scan_idx    = 0;
      owner_n     = owner;
      owner_vld_n = owner_vld;
      burst_cnt_n = burst_cnt;
      last_n      = last;
      gnt         = '0;
      rvalid      = '0;
      rdata       = ram_dout;
      ram_we      = 1'b0;
      ram_oe      = 1'b0;
      ram_address = '0;
      ram_din     = '0;

      owner_keep = owner_vld && req[owner] && (burst_cnt < CW'(MAX_BURST));
      if (owner_keep) begin
         gnt_idx = owner;
         gnt_any = 1'b1;
      end else begin
         // Scan from last+1 with wrap; when everyone else is idle this lands back on last
         for (int k = 1; k <= int'(NREQ); k++) begin
            scan_idx = (int'(last) + k) % NREQ;
            if (!gnt_any && req[scan_idx]) begin
               gnt_any = 1'b1;
               gnt_idx = IDXW'(scan_idx);
            end
         end
      end
      if (reset) gnt_any = 1'b0;

      if (gnt_any) begin
         if (owner_keep) begin
            burst_cnt_n = burst_cnt + CW'(1);
         end else begin
            owner_n     = gnt_idx;
            owner_vld_n = 1'b1;
            burst_cnt_n = CW'(1);
            last_n      = gnt_idx;
         end
      end else begin
         owner_vld_n = 1'b0;
         burst_cnt_n = '0;
      end

      for (int i = 0; i < int'(NREQ); i++) begin
         if (gnt_any && gnt_idx == IDXW'(i)) begin
            gnt[i]      = 1'b1;
            ram_we      = req_we[i];
            ram_oe      = 1'b1;
            ram_address = req_address[AW*i +: AW];
            ram_din     = req_din[WIDTH*i +: WIDTH];
         end
      end

      rd_pend_n = gnt & ~req_we;
      if (!reset) rvalid = rd_pend;
   end

endmodule

// File: tb/tb_dualportram_port_arbiter.sv
// Directed bench for dualportram_port_arbiter with a behavioural 1-cycle-latency RAM port.
module tb_dualportram_port_arbiter;

   localparam int unsigned NREQ  = 4;
   localparam int unsigned WIDTH = 32;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NREQ-1:0]       req;
   logic [NREQ-1:0]       req_we;
   logic [NREQ*32-1:0]    req_address;
   logic [NREQ*WIDTH-1:0] req_din;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       rvalid;
   logic [WIDTH-1:0]      rdata;
   logic                  ram_we;
   logic                  ram_oe;
   logic [31:0]           ram_address;
   logic [WIDTH-1:0]      ram_din;
   logic [WIDTH-1:0]      ram_dout;

   logic [WIDTH-1:0] mem [16];
   int errors = 0;
   int checks = 0;

   dualportram_port_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_BURST(4)) dut (
      .clk(clk), .reset(reset), .req(req), .req_we(req_we),
      .req_address(req_address), .req_din(req_din), .gnt(gnt), .rvalid(rvalid),
      .rdata(rdata), .ram_we(ram_we), .ram_oe(ram_oe), .ram_address(ram_address),
      .ram_din(ram_din), .ram_dout(ram_dout)
   );

   always #5 clk = ~clk;

   // RAM model: reset loads mem[5]=A5A5, others 0x100+addr
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) mem[i] <= (i == 5) ? 32'hA5A5 : 32'h100 + 32'(i);
         ram_dout <= '0;
      end else if (ram_oe) begin
         if (ram_we) mem[ram_address[3:0]] <= ram_din;
         else ram_dout <= mem[ram_address[3:0]];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_addr(input int i, input logic [31:0] a);
      req_address[32*i +: 32] = a;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      req   = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req = 4'b1111; req_we = '0; req_address = '0; req_din = '0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
         checks++; if (ram_oe !== 1'b0 || ram_we !== 1'b0) begin errors++; $display("FAIL reset_oe_we got=%b%b exp=00", ram_oe, ram_we); end
         tick();
      end
      @(negedge clk);
      checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL reset_rvalid got=%b exp=0000", rvalid); end
      tick();
      reset = 1'b0;
      req = '0;
   endtask

   task automatic test_single_read();
      req = 4'b0001; req_we = '0; set_addr(0, 5);
      @(negedge clk);
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt got=%b exp=0001", gnt); end
      checks++; if (ram_address !== 32'd5 || ram_oe !== 1'b1 || ram_we !== 1'b0) begin errors++; $display("FAIL single_drive addr=%0d oe=%b we=%b exp=5 1 0", ram_address, ram_oe, ram_we); end
      tick();
      req = '0;
      @(negedge clk);
      checks++; if (rvalid !== 4'b0001) begin errors++; $display("FAIL single_rvalid got=%b exp=0001", rvalid); end
      checks++; if (rdata !== 32'hA5A5) begin errors++; $display("FAIL single_rdata got=%h exp=0000a5a5", rdata); end
      checks++; if (gnt !== 4'b0000 || ram_address !== 32'd0) begin errors++; $display("FAIL idle_drive gnt=%b addr=%0d exp=0000 0", gnt, ram_address); end
      tick();
   endtask

   task automatic test_rr_pointer();
      req = 4'b0010; req_we = '0; set_addr(1, 9);
      @(negedge clk);
      checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rr_setup_gnt got=%b exp=0010", gnt); end
      tick();
      req = '0;
      tick();
      req = 4'b1010; set_addr(3, 11);
      @(negedge clk);
      checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL rr_first_gnt got=%b exp=1000", gnt); end
      tick();
      req = 4'b0010;
      @(negedge clk);
      checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rr_second_gnt got=%b exp=0010", gnt); end
      checks++; if (rvalid !== 4'b1000 || rdata !== 32'h10B) begin errors++; $display("FAIL rr_read3 rvalid=%b rdata=%h exp=1000 0000010b", rvalid, rdata); end
      tick();
      req = '0;
      tick();
   endtask

   task automatic test_round_robin();
      int exp_i;
      int prev;
      logic [3:0] eg;
      logic [3:0] ev;
      apply_reset();
      req = 4'b1111; req_we = '0;
      for (int i = 0; i < 4; i++) set_addr(i, 32'(8 + i));
      prev = -1;
      for (int c = 0; c < 17; c++) begin
         exp_i = (c / 4) % 4;
         eg = 4'(1) << exp_i;
         ev = (prev < 0) ? 4'b0000 : 4'(1) << prev;
         @(negedge clk);
         checks++; if (gnt !== eg) begin errors++; $display("FAIL rr_burst_gnt cyc=%0d got=%b exp=%b", c, gnt, eg); end
         checks++; if (ram_address !== 32'(8 + exp_i)) begin errors++; $display("FAIL rr_burst_addr cyc=%0d got=%0d exp=%0d", c, ram_address, 8 + exp_i); end
         checks++; if (rvalid !== ev) begin errors++; $display("FAIL rr_burst_rvalid cyc=%0d got=%b exp=%b", c, rvalid, ev); end
         if (prev >= 0) begin
            checks++; if (rdata !== 32'h108 + 32'(prev)) begin errors++; $display("FAIL rr_burst_rdata cyc=%0d got=%h exp=%h", c, rdata, 32'h108 + 32'(prev)); end
         end
         prev = exp_i;
         tick();
      end
      req = '0;
      tick();
   endtask

   task automatic test_single_owner();
      apply_reset();
      req = 4'b0100; req_we = '0; set_addr(2, 10);
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL solo_gnt cyc=%0d got=%b exp=0100", c, gnt); end
         if (c > 0) begin
            checks++; if (rvalid !== 4'b0100 || rdata !== 32'h10A) begin errors++; $display("FAIL solo_read cyc=%0d rvalid=%b rdata=%h exp=0100 0000010a", c, rvalid, rdata); end
         end
         tick();
      end
      req = '0;
      tick();
   endtask

   task automatic test_write_then_read();
      apply_reset();
      req = 4'b0010; req_we = 4'b0010; set_addr(1, 7); req_din[32*1 +: 32] = 32'h1234;
      @(negedge clk);
      checks++; if (gnt !== 4'b0010 || ram_we !== 1'b1) begin errors++; $display("FAIL wr_gnt gnt=%b we=%b exp=0010 1", gnt, ram_we); end
      checks++; if (ram_address !== 32'd7 || ram_din !== 32'h1234) begin errors++; $display("FAIL wr_drive addr=%0d din=%h exp=7 00001234", ram_address, ram_din); end
      tick();
      req = 4'b1000; req_we = '0; set_addr(3, 7);
      @(negedge clk);
      checks++; if (gnt !== 4'b1000 || ram_we !== 1'b0) begin errors++; $display("FAIL rd_gnt gnt=%b we=%b exp=1000 0", gnt, ram_we); end
      checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL wr_no_rvalid got=%b exp=0000", rvalid); end
      tick();
      req = '0;
      @(negedge clk);
      checks++; if (rvalid !== 4'b1000 || rdata !== 32'h1234) begin errors++; $display("FAIL raw_read rvalid=%b rdata=%h exp=1000 00001234", rvalid, rdata); end
      tick();
   endtask

   task automatic test_reset_mid_read();
      apply_reset();
      req = 4'b0001; req_we = '0; set_addr(0, 5); set_addr(1, 9);
      @(negedge clk);
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL mid_gnt got=%b exp=0001", gnt); end
      tick();
      reset = 1'b1;
      @(negedge clk);
      checks++; if (rvalid !== 4'b0000 || gnt !== 4'b0000) begin errors++; $display("FAIL mid_reset rvalid=%b gnt=%b exp=0000 0000", rvalid, gnt); end
      tick();
      reset = 1'b0;
      req = 4'b0011;
      @(negedge clk);
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL post_reset_gnt got=%b exp=0001", gnt); end
      checks++; if (rvalid !== 4'b0000) begin errors++; $display("FAIL post_reset_rvalid got=%b exp=0000", rvalid); end
      tick();
      req = '0;
      tick();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_rr_pointer();
      test_round_robin();
      test_single_owner();
      test_write_then_read();
      test_reset_mid_read();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
